// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first through one full-subtractor cell
// with a registered borrow, behind valid/ready handshakes on both sides.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned LAST_BIT = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   a_sr_q,      a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,      b_sr_d;
    logic [WIDTH-1:0]   r_q,         r_d;
    logic               brw_q,       brw_d;
    logic               a_msb_q,     a_msb_d;
    logic               b_msb_q,     b_msb_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   diff_q,      diff_d;
    logic               borrow_q,    borrow_d;
    logic               ovf_q,       ovf_d;

    logic               bit_a;
    logic               bit_b;
    logic               d_bit;
    logic               brw_nxt;
    logic               last_bit;

    // Full-subtractor cell on the current LSBs.
    assign bit_a    = a_sr_q[0];
    assign bit_b    = b_sr_q[0];
    assign d_bit    = bit_a ^ bit_b ^ brw_q;
    assign brw_nxt  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & brw_q);
    assign last_bit = (cnt_q == CNT_W'(LAST_BIT));

    // Acceptance is blocked in the same cycle reset is asserted.
    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            r_q         <= '0;
            brw_q       <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            r_q         <= r_d;
            brw_q       <= brw_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        r_d         = r_q;
        brw_d       = brw_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                // Result fills from the top; written as a shift-or so WIDTH=1 needs no slice.
                r_d    = (r_q >> 1) | (WIDTH'(d_bit) << LAST_BIT);
                brw_d  = brw_nxt;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // The bit produced now is the result MSB.
                    diff_d      = (r_q >> 1) | (WIDTH'(d_bit) << LAST_BIT);
                    borrow_d    = brw_nxt;
                    ovf_d       = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 instance for the main cases and a
// WIDTH=1 instance for the single-bit edge case.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow_out;
    logic       overflow;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] diff1;
    logic       borrow_out1;
    logic       overflow1;

    int total;
    int bad;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .borrow_out(borrow_out1), .overflow(overflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready(input string name);
        for (int i = 0; i < 30 && !in_ready; i++) step();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s in_ready_wait: got %b want 1", name, in_ready);
        end
    endtask

    // Accept one operation with out_ready held high and check result, latency and release.
    task automatic do_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic eo);
        int cycles;
        wait_in_ready(name);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = av;
        b = bv;
        step();
        in_valid = 1'b0;
        a = ~av;
        b = ~bv;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_in_ready: got %b want 0", name, in_ready);
        end
        cycles = 0;
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) begin
            step();
            cycles++;
        end
        total++;
        if (cycles !== 8 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s latency: got %0d valid=%b want 8", name, cycles, out_valid);
        end
        total++;
        if (diff !== ed) begin
            bad++;
            $display("FAIL %s diff: got %h want %h", name, diff, ed);
        end
        total++;
        if (borrow_out !== eb) begin
            bad++;
            $display("FAIL %s borrow_out: got %b want %b", name, borrow_out, eb);
        end
        total++;
        if (overflow !== eo) begin
            bad++;
            $display("FAIL %s overflow: got %b want %b", name, overflow, eo);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s release: got valid=%b ready=%b want valid=0 ready=1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_handshake: got ready=%b valid=%b want 0 0", in_ready, out_valid);
        end
        total++;
        if (diff !== 8'h00 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got diff=%h brw=%b ovf=%b want 00 0 0",
                     diff, borrow_out, overflow);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got ready=%b ready1=%b want 1 1", in_ready, in_ready1);
        end
    endtask

    task automatic test_basic();
        do_op("basic", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        do_op("wrap", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        do_op("ovf_neg", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        do_op("ovf_pos", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_op("b2b_0", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        do_op("b2b_1", 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0);
        do_op("b2b_2", 8'hC8, 8'h64, 8'h64, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        int n;
        wait_in_ready("bp");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'h35;
        b = 8'hC3;
        step();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = 8'(i * 37 + 5);
            b = 8'(i * 11 + 200);
            step();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 8'h72
                || borrow_out !== 1'b1 || overflow !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%b d=%h b=%b o=%b want 1 0 72 1 0",
                         i, out_valid, in_ready, diff, borrow_out, overflow);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 8'h72) begin
            bad++;
            $display("FAIL bp_release: got v=%b r=%b d=%h want 0 1 72", out_valid, in_ready, diff);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_single: got v=%b r=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        wait_in_ready("rmid");
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 8'h5A;
        b = 8'h3C;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || diff !== 8'h00
            || borrow_out !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL rmid_reset: got v=%b r=%b d=%h b=%b o=%b want 0 0 00 0 0",
                     out_valid, in_ready, diff, borrow_out, overflow);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rmid_ready: got %b want 1", in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rmid_no_valid: got %b want 0", seen);
        end
        do_op("rmid_after", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    endtask

    task automatic test_width1();
        for (int i = 0; i < 10 && !in_ready1; i++) step();
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        a1 = 1'b0;
        b1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        a1 = 1'b1;
        b1 = 1'b0;
        step();
        total++;
        if (out_valid1 !== 1'b1 || diff1 !== 1'b1 || borrow_out1 !== 1'b1) begin
            bad++;
            $display("FAIL w1_result: got v=%b d=%b b=%b want 1 1 1",
                     out_valid1, diff1, borrow_out1);
        end
        step();
        total++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            bad++;
            $display("FAIL w1_release: got v=%b r=%b want 0 1", out_valid1, in_ready1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        a1         = '0;
        b1         = '0;

        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_width1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
